sipo_rx: RTL
============

// Module: sipo_rx
// PURPOSE
// - Serial-in parallel-out receiver. It is the far end of the LSB-first PISO serial link.
// - Samples sin on each shift_en strobe and assembles WIDTH-bit words, first bit received = bit 0.
// - Presents each completed word on a valid/ready output port and flags words lost to backpressure.
// - Sits between the serial link and the parallel consumer logic.
// PARAMETERS
// - WIDTH  4                 word width in bits; legal range >= 2
// - CNT_W  $clog2(WIDTH)     bit-counter width; derived, not overridden
// PORTS
// - clk          in   1      clock; all logic on posedge
// - rst          in   1      reset, synchronous, active-high
// - sin          in   1      serial data bit; valid only when shift_en=1
// - shift_en     in   1      bit strobe: sample sin this cycle; gaps between strobes allowed
// - frame_start  in   1      resync: discard the partial word and restart at bit 0
// - dout_ready   in   1      consumer accepts dout this cycle
// - overrun_clr  in   1      clears the sticky overrun flag
// - dout         out  WIDTH  received word, LSB = first bit received
// - dout_valid   out  1      dout holds an unaccepted word
// - overrun      out  1      sticky: a completed word was dropped
// - busy         out  1      partial word in progress (state RECV)
// - bit_cnt      out  CNT_W  bits collected of the current word (0..WIDTH-1)
// BEHAVIOUR
// - Reset values: dout=0, dout_valid=0, overrun=0, busy=0, bit_cnt=0, state IDLE, shift register=0.
// - rst in mid-word discards the partial word and any pending dout.
// - Shift: when shift_en=1, shreg <= {sin, shreg[WIDTH-1:1]} and bit_cnt <= bit_cnt+1.
// - FSM IDLE: shift_en=1 -> RECV with bit_cnt=1.
// - FSM RECV: the strobe with bit_cnt==WIDTH-1 completes the word -> IDLE, bit_cnt=0.
// - FSM RECV: no strobe -> hold state and counter.
// - Completion: completed word = {sin, shreg[WIDTH-1:1]}.
// - Completion latency: registered into dout on the same edge that samples the last bit;
//   dout_valid is high from the next cycle.
// - Handshake: the word transfers on any cycle with dout_valid && dout_ready; after that edge dout_valid=0.
// - Handshake: dout and dout_valid are stable while dout_valid && !dout_ready.
// - Completion with dout_valid=1 and dout_ready=1 in the same cycle: dout loads the new word,
//   dout_valid stays 1, no overrun.
// - Completion with dout_valid=1 and dout_ready=0: new word dropped, dout keeps the old word,
//   overrun <= 1.
// - overrun stays set until overrun_clr=1 or rst.
// - overrun_clr and an overrun event in the same cycle: set wins, overrun=1.
// - frame_start=1 with shift_en=0: bit_cnt <= 0, state IDLE, partial word discarded.
// - frame_start=1 with shift_en=1: the sampled bit becomes bit 0 of the new word; bit_cnt <= 1, state RECV.
// - frame_start never affects dout, dout_valid or overrun.
// - Counter wrap: bit_cnt never reaches WIDTH; it returns to 0 on completion.
// STRUCTURE
// - Package sipo_pkg:
//   - state enum {IDLE, RECV}
//   - localparam computing CNT_W from WIDTH
// - Top: shift register, bit counter and FSM.
// - Sub-module sipo_out_stage(WIDTH): output holding register, dout_valid/dout_ready handshake
//   and overrun flag. Inputs: word_done and word.
// TESTING (WIDTH=4)
// - Strobe sin=1,1,0,1 on consecutive cycles, ready=0
//   -> dout=4'hB, dout_valid=1 from the cycle after the 4th strobe, held until ready=1, then dout_valid=0.
// - ready tied 1, continuous strobes of words 4'hA then 4'h5
//   -> each word valid exactly 1 cycle, no gap, overrun=0.
// - ready=0, send 4'h3 then 4'hC
//   -> dout stays 4'h3, overrun=1.
//   Then overrun_clr pulse -> overrun=0 and dout still 4'h3.
// - Word 4'h3 pending, ready=1 exactly on the 4th-bit cycle of 4'hC
//   -> dout=4'hC, dout_valid=1, overrun=0.
// - 2 bits sent, then frame_start (no strobe), then bits 0,1,1,0
//   -> bit_cnt=0 after the resync, dout=4'h6.
//   Repeat with frame_start coincident with the first bit -> same result.
// - rst after 3 bits of a word with a word pending
//   -> all outputs 0 next cycle; next 4 bits 1,0,0,1 -> dout=4'h9.
// - Strobes separated by random 0-3 idle cycles
//   -> same words as back-to-back strobes; busy=1 only mid-word.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } sipo_state_e;

    localparam int SIPO_WIDTH_DEF = 4;

    function automatic int calc_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int SIPO_CNT_W_DEF = calc_cnt_w(SIPO_WIDTH_DEF);

endpackage

// File: rtl/sipo_out_stage.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
module sipo_out_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word,
    input  logic             dout_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic can_load;
    logic drop;

    // A slot frees up in the same cycle the held word is taken.
    assign can_load = !dout_valid || dout_ready;
    assign drop     = word_done && !can_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (word_done && can_load) begin
            dout       <= word;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// LSB-first serial-in parallel-out receiver: shift register, bit counter and word FSM.
//   state | meaning
//   IDLE  | no partial word, bit_cnt = 0
//   RECV  | partial word in progress, bit_cnt = bits collected
module sipo_rx
    import sipo_pkg::*;
#(
    parameter  int WIDTH = SIPO_WIDTH_DEF,
    localparam int CNT_W = calc_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             shift_en,
    input  logic             frame_start,
    input  logic             dout_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sipo_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] word;
    logic             word_done;

    // Bit 0 of the register would only ever fall off the end, so only the upper bits are kept.
    assign word = {sin, shreg};

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= word[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        word_done = 1'b0;
        if (frame_start) begin
            // Resync takes priority; a coincident strobe becomes bit 0 of the new word.
            if (shift_en) begin
                state_nxt = RECV;
                cnt_nxt   = CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (shift_en) begin
                        state_nxt = RECV;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                RECV: begin
                    if (shift_en) begin
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            word_done = 1'b1;
                        end else begin
                            cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign busy = (state == RECV);

    sipo_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk        (clk),
        .rst        (rst),
        .word_done  (word_done),
        .word       (word),
        .dout_ready (dout_ready),
        .overrun_clr(overrun_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

endmodule
